pipeline_controller: RTL and testbench

//   Sequences the 5-stage processor pipeline registers (fetch, decode, execute, memory, store).

---
 rtl/pipeline_controller.sv | 133 +++++++++++++
 tb/tb_pipeline_controller.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_controller.sv
// Pipeline sequencer: per-stage load enables and bubble flushes for the
// 5-stage pipeline, covering load-use stalls, branch flushes, memory waits and halt.
module pipeline_controller #(
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int MEM_TIMEOUT       = 255,
  parameter int STALL_COUNT_WIDTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [REG_ADDR_WIDTH-1:0]    decode_rs,
  input  logic [REG_ADDR_WIDTH-1:0]    decode_rt,
  input  logic                         decode_uses_rt,
  input  logic [REG_ADDR_WIDTH-1:0]    execute_rd,
  input  logic                         execute_is_load,
  input  logic                         branch_taken,
  input  logic                         memory_request,
  input  logic                         memory_ready,
  input  logic                         halt,
  output logic                         fetch_enable,
  output logic                         decode_enable,
  output logic                         execute_enable,
  output logic                         memory_enable,
  output logic                         store_enable,
  output logic                         decode_flush,
  output logic                         execute_flush,
  output logic                         memory_timeout,
  output logic [STALL_COUNT_WIDTH-1:0] stall_count,
  output logic [1:0]                   state
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } state_t;

  state_t                       cur_state, nxt_state;
  logic [WAIT_W-1:0]            wait_count, nxt_wait;
  logic                         timeout_q, nxt_timeout;
  logic [STALL_COUNT_WIDTH-1:0] stall_q;
  logic                         load_use;
  logic                         fe_c, de_c, ee_c, me_c, se_c, df_c, xf_c;

  function automatic logic [STALL_COUNT_WIDTH-1:0] sat_inc(
    input logic [STALL_COUNT_WIDTH-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  // Register 0 is hardwired, so a load targeting it can never feed decode.
  assign load_use = execute_is_load && (execute_rd != '0) &&
                    ((execute_rd == decode_rs) ||
                     (decode_uses_rt && (execute_rd == decode_rt)));

  always_comb begin
    fe_c        = 1'b0;
    de_c        = 1'b0;
    ee_c        = 1'b0;
    me_c        = 1'b0;
    se_c        = 1'b0;
    df_c        = 1'b0;
    xf_c        = 1'b0;
    nxt_state   = cur_state;
    nxt_wait    = wait_count;
    nxt_timeout = timeout_q;
    case (cur_state)
      RUN: begin
        if (halt) begin
          nxt_state = HALTED;
        end else if (memory_request && !memory_ready) begin
          nxt_state = MEM_WAIT;
          nxt_wait  = WAIT_W'(1);
        end else if (branch_taken) begin
          {fe_c, de_c, ee_c, me_c, se_c} = '1;
          df_c = 1'b1;
          xf_c = 1'b1;
        end else if (load_use) begin
          // Hold fetch/decode, let the load advance, and bubble execute once.
          {ee_c, me_c, se_c} = '1;
          xf_c = 1'b1;
        end else begin
          {fe_c, de_c, ee_c, me_c, se_c} = '1;
        end
      end
      MEM_WAIT: begin
        if (memory_ready) begin
          {fe_c, de_c, ee_c, me_c, se_c} = '1;
          nxt_state = RUN;
        end else if (wait_count == TIMEOUT_CNT) begin
          nxt_timeout = 1'b1;
          nxt_state   = HALTED;
        end else begin
          nxt_wait = wait_count + 1'b1;
        end
      end
      HALTED: begin
      end
      default: nxt_state = HALTED;
    endcase
  end

  // Enables and flushes are forced low for as long as reset is asserted.
  assign fetch_enable   = reset & fe_c;
  assign decode_enable  = reset & de_c;
  assign execute_enable = reset & ee_c;
  assign memory_enable  = reset & me_c;
  assign store_enable   = reset & se_c;
  assign decode_flush   = reset & df_c;
  assign execute_flush  = reset & xf_c;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_state  <= RUN;
      wait_count <= '0;
      timeout_q  <= 1'b0;
      stall_q    <= '0;
    end else begin
      cur_state  <= nxt_state;
      wait_count <= nxt_wait;
      timeout_q  <= nxt_timeout;
      if ((cur_state != HALTED) && !fe_c)
        stall_q <= sat_inc(stall_q);
    end
  end

  assign memory_timeout = timeout_q;
  assign stall_count    = stall_q;
  assign state          = cur_state;

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: vector table, directed
// multi-cycle sequences and randomized traffic against a cycle model.
module tb_pipeline_controller;

  localparam int RAW  = 5;
  localparam int TO   = 4;
  localparam int SCW  = 4;
  localparam int SMAX = (1 << SCW) - 1;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [RAW-1:0] decode_rs = '0, decode_rt = '0, execute_rd = '0;
  logic           decode_uses_rt = 1'b0, execute_is_load = 1'b0, branch_taken = 1'b0;
  logic           memory_request = 1'b0, memory_ready = 1'b0, halt = 1'b0;
  logic           fetch_enable, decode_enable, execute_enable, memory_enable, store_enable;
  logic           decode_flush, execute_flush, memory_timeout;
  logic [SCW-1:0] stall_count;
  logic [1:0]     state;

  pipeline_controller #(
    .REG_ADDR_WIDTH(RAW), .MEM_TIMEOUT(TO), .STALL_COUNT_WIDTH(SCW)
  ) dut (
    .clock(clock), .reset(reset),
    .decode_rs(decode_rs), .decode_rt(decode_rt), .decode_uses_rt(decode_uses_rt),
    .execute_rd(execute_rd), .execute_is_load(execute_is_load),
    .branch_taken(branch_taken), .memory_request(memory_request),
    .memory_ready(memory_ready), .halt(halt),
    .fetch_enable(fetch_enable), .decode_enable(decode_enable),
    .execute_enable(execute_enable), .memory_enable(memory_enable),
    .store_enable(store_enable), .decode_flush(decode_flush),
    .execute_flush(execute_flush), .memory_timeout(memory_timeout),
    .stall_count(stall_count), .state(state)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model state: 0 run, 1 waiting on memory, 2 halted.
  int m_state = 0;
  int m_wait  = 0;
  int m_stall = 0;
  bit m_tmo   = 1'b0;

  typedef struct {
    logic [RAW-1:0] rs, rt;
    logic           ut;
    logic [RAW-1:0] rd;
    logic           ld, br, mq, mr, h;
    logic [6:0]     o;      // {fe,de,ee,me,se,df,xf}
    logic [1:0]     st;
    int             stall;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {fetch_enable, decode_enable, execute_enable, memory_enable,
            store_enable, decode_flush, execute_flush};
  endfunction

  function automatic logic [6:0] model_out();
    bit hz;
    if (reset !== 1'b1) return 7'b0;
    hz = execute_is_load && (execute_rd != 0) &&
         ((execute_rd == decode_rs) || (decode_uses_rt && (execute_rd == decode_rt)));
    if (m_state == 0) begin
      if (halt || (memory_request && !memory_ready)) return 7'b0;
      if (branch_taken) return 7'b1111111;
      if (hz)           return 7'b0011101;
      return 7'b1111100;
    end
    if (m_state == 1) return memory_ready ? 7'b1111100 : 7'b0;
    return 7'b0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_wait = 0; m_stall = 0; m_tmo = 1'b0;
  endtask

  task automatic model_edge(input logic [6:0] o);
    if (reset !== 1'b1) begin
      model_reset();
      return;
    end
    if (m_state != 2 && !o[6] && m_stall < SMAX) m_stall = m_stall + 1;
    if (m_state == 0) begin
      if (halt) m_state = 2;
      else if (memory_request && !memory_ready) begin m_state = 1; m_wait = 1; end
    end else if (m_state == 1) begin
      if (memory_ready) m_state = 0;
      else if (m_wait == TO) begin m_tmo = 1'b1; m_state = 2; end
      else m_wait = m_wait + 1;
    end
  endtask

  task automatic drive(input int rs, input int rt, input bit ut, input int rd, input bit ld,
                       input bit br, input bit mq, input bit mr, input bit h);
    decode_rs = RAW'(rs); decode_rt = RAW'(rt); decode_uses_rt = ut;
    execute_rd = RAW'(rd); execute_is_load = ld; branch_taken = br;
    memory_request = mq; memory_ready = mr; halt = h;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Entered just after a falling edge with inputs already applied.
  task automatic run_cycle(input string tag);
    logic [6:0] e;
    if (reset !== 1'b1) model_reset();
    #2;
    e = model_out();
    check({tag, " enables"}, 32'(outs()), 32'(e));
    @(posedge clock);
    model_edge(e);
    #1;
    check({tag, " state"}, 32'(state), 32'(m_state));
    check({tag, " stall"}, 32'(stall_count), 32'(m_stall));
    check({tag, " timeout"}, 32'(memory_timeout), 32'(m_tmo));
    @(negedge clock);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    idle();
    run_cycle("rst");
    reset = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1111100, 2'd0, 0};
    vecs[1]  = '{5, 0, 0, 5, 1, 0, 0, 0, 0, 7'b0011101, 2'd0, 1};
    vecs[2]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 7'b1111100, 2'd0, 0};
    vecs[3]  = '{3, 7, 1, 7, 1, 0, 0, 0, 0, 7'b0011101, 2'd0, 1};
    vecs[4]  = '{3, 7, 0, 7, 1, 0, 0, 0, 0, 7'b1111100, 2'd0, 0};
    vecs[5]  = '{5, 5, 1, 5, 0, 0, 0, 0, 0, 7'b1111100, 2'd0, 0};
    vecs[6]  = '{5, 0, 0, 5, 1, 1, 0, 0, 0, 7'b1111111, 2'd0, 0};
    vecs[7]  = '{1, 2, 1, 3, 0, 1, 0, 0, 0, 7'b1111111, 2'd0, 0};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 7'b0000000, 2'd2, 1};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b0000000, 2'd1, 1};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 7'b1111100, 2'd0, 0};
    vecs[11] = '{5, 0, 0, 5, 1, 1, 0, 0, 1, 7'b0000000, 2'd2, 1};
    vecs[12] = '{5, 0, 0, 5, 1, 1, 1, 0, 0, 7'b0000000, 2'd1, 1};
    vecs[13] = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 7'b1111100, 2'd0, 0};

    @(negedge clock);

    // Reset held for 3 cycles with random inputs, then released.
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 1),
            $urandom_range(0, 31), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      #1;
      check("reset enables", 32'(outs()), 32'd0);
      check("reset state", 32'(state), 32'd0);
      check("reset stall", 32'(stall_count), 32'd0);
      run_cycle("reset hold");
    end
    reset = 1'b1;
    idle();
    #1;
    check("release enables", 32'(outs()), 32'b1111100);
    run_cycle("release");

    // Single-cycle vectors, each from a fresh reset.
    for (int v = 0; v < 14; v++) begin
      logic [6:0] e;
      pulse_reset();
      drive(vecs[v].rs, vecs[v].rt, vecs[v].ut, vecs[v].rd, vecs[v].ld,
            vecs[v].br, vecs[v].mq, vecs[v].mr, vecs[v].h);
      #2;
      e = model_out();
      check($sformatf("vec%0d enables", v), 32'(outs()), 32'(vecs[v].o));
      @(posedge clock);
      model_edge(e);
      #1;
      check($sformatf("vec%0d state", v), 32'(state), 32'(vecs[v].st));
      check($sformatf("vec%0d stall", v), 32'(stall_count), 32'(vecs[v].stall));
      @(negedge clock);
    end

    // Memory wait: three not-ready cycles, then ready.
    pulse_reset();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("memwait enables low", 32'(fetch_enable | store_enable), 32'd0);
      run_cycle("memwait");
      check("memwait in wait", 32'(state), 32'd1);
    end
    memory_ready = 1'b1;
    #1;
    check("memwait ready enables", 32'(outs()), 32'b1111100);
    run_cycle("memwait done");
    check("memwait back to run", 32'(state), 32'd0);
    check("memwait stall total", 32'(stall_count), 32'd3);

    // Timeout with ready never asserted.
    pulse_reset();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      run_cycle("timeout");
      if (i == 4) begin
        check("timeout edge4 state", 32'(state), 32'd1);
        check("timeout edge4 flag", 32'(memory_timeout), 32'd0);
      end
    end
    check("timeout edge5 state", 32'(state), 32'd2);
    check("timeout edge5 flag", 32'(memory_timeout), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) run_cycle("timeout persist");
    check("timeout sticky", 32'(memory_timeout), 32'd1);
    reset = 1'b0;
    #1;
    check("timeout cleared", 32'(memory_timeout), 32'd0);
    check("timeout state cleared", 32'(state), 32'd0);
    run_cycle("timeout reset");
    reset = 1'b1;

    // Halt ignored in MEM_WAIT; reset while waiting returns to RUN at once.
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    run_cycle("wait enter");
    drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
    run_cycle("wait halt ignored");
    check("halt ignored in wait", 32'(state), 32'd1);
    reset = 1'b0;
    #1;
    check("async reset in wait", 32'(state), 32'd0);
    check("async reset enables", 32'(outs()), 32'd0);
    run_cycle("wait reset");
    reset = 1'b1;

    // Continuous load-use drives the stall counter into saturation.
    idle();
    drive(5, 0, 0, 5, 1, 0, 0, 0, 0);
    for (int i = 0; i < SMAX + 5; i++) run_cycle("saturate");
    check("stall saturated", 32'(stall_count), 32'(SMAX));

    // Randomized traffic against the model.
    pulse_reset();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 1), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 2) == 0), $urandom_range(0, 1), ($urandom_range(0, 39) == 0));
      if ($urandom_range(0, 63) == 0 || (m_state == 2 && $urandom_range(0, 3) == 0))
        reset = 1'b0;
      else
        reset = 1'b1;
      run_cycle("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
